md_issue_queue: RTL
===================

Name: md_issue_queue

Overview:
- Sits in E stage, directly upstream of the HI/LO multiply-divide unit.
- Accepts mult/div-class, madd/msub-class and mthi/mtlo requests from the pipeline and holds them in an in-order FIFO.
- Presents each request to the MD unit for exactly one cycle, only when that unit is not busy.
- Generates the pipeline stall for a full queue and for mfhi/mflo hazards.

Parameters:
- DEPTH, 2: FIFO entries; power of two, at least 2.
- OP_W, 4: width of the MD opcode field.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  E-stage instruction carries an MD opcode this cycle.
- in_op  input  OP_W  MD opcode.
- in_d1  input  32  rs operand.
- in_d2  input  32  rt operand.
- flush  input  1  exception/eret; discards all queued, not yet issued entries.
- md_busy  input  1  busy from MD unit.
- out_op  output  OP_W  opcode to MD unit; 0 when idle.
- out_d1  output  32  D1 to MD unit.
- out_d2  output  32  D2 to MD unit.
- stall  output  1  freeze F/D/E this cycle.
- pending  output  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Opcode classes:
  - Start ops: 1 mult, 2 multu, 3 div, 4 divu, 9 madd, 10 maddu, 11 msub, 12 msubu.
  - Write ops: 7 mthi, 8 mtlo.
  - Read ops: 5 mfhi, 6 mflo.
  - Opcodes 0 and 13-15 are ignored: no enqueue, no stall.
- Enqueue ops are start ops and write ops. Every enqueue op goes through the FIFO; there is no bypass. Minimum latency from acceptance edge to out_op valid is 1 cycle.
- issue = (pending != 0) && !md_busy, combinational.
  - When issue=1: out_op = head.op, out_d1 = head.d1, out_d2 = head.d2.
  - When issue=0: out_op = 0, and out_d1/out_d2 = 0.
- Pop on the posedge where issue=1. Each entry is presented for exactly one cycle.
  - A start op raises md_busy in the following cycle, which blocks the next issue.
  - A write op does not raise md_busy, so back-to-back write ops issue on consecutive cycles.
- Accept = in_valid && enqueue op && !flush && (pending < DEPTH || issue).
  - Push and pop in the same cycle on a full FIFO are allowed.
- stall = in_valid && !flush && ((enqueue op && pending == DEPTH && !issue) || (read op && (pending != 0 || md_busy))).
  - An mfhi/mflo holds until the queue is empty and md_busy is low; it proceeds in that same cycle.
- A stalled instruction is not accepted. The pipeline re-presents the same in_* next cycle.
- Flush:
  - On a posedge with flush=1, pending becomes 0 and the read/write pointers are equalised.
  - An issue asserted in the same cycle is still delivered, because the MD unit samples it; the popped entry is simply gone.
  - An incoming request in the flush cycle is dropped.
  - Flush does not affect an op already running in the MD unit.
- Pointers wrap modulo DEPTH. pending saturates by construction: there is never a push while full without a pop.
- Reset, synchronous:
  - pending = 0, pointers = 0, and all FIFO entries are cleared to 0.
  - Outputs become out_op = 0, out_d1 = 0, out_d2 = 0, stall = 0 (given reset state, md_busy = 0 is not required).
  - Reset mid-operation discards everything queued; the MD unit is reset by the same signal.
- Outputs are combinational from registered state plus md_busy, flush and in_*. There is no combinational path from out_op back to md_busy inside this block.

Test Plan:
- Single issue: in_valid, op=1, d1=3, d2=5, md_busy=0 at cycle 0 -> cycle 1: out_op=1, out_d1=3, out_d2=5, pending=1; cycle 2: out_op=0, pending=0.
- mfhi hazard: mult accepted at cycle 0, md_busy high cycles 2-6, mfhi presented from cycle 1 -> stall=1 on cycles 1-6, stall=0 on cycle 7 (md_busy low).
- Full queue: DEPTH=2, md_busy=1, push op=1, op=3, then op=7 -> third request stall=1, pending=2. Drop md_busy -> same cycle issue op=1 with op=7 accepted, pending stays 2.
- Ordering: div queued, then mthi d1=0xDEADBEEF, md_busy high 10 cycles after div issue -> out_op=7 with out_d1=0xDEADBEEF appears only on the first cycle md_busy=0.
- Flush: pending=2, md_busy=1, flush=1 with in_valid op=9 -> next cycle pending=0, stall=0, out_op=0 once md_busy falls.
- Reset mid-stream: pending=2, reset=1 for one cycle -> pending=0, out_op=0, stall=0; a new op=2 afterwards issues normally.

Source files
------------

// File: rtl/md_issue_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_issue_queue_if                                                          |
// | Pipeline / MD-unit side signals of the multiply-divide issue queue.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface md_issue_queue_if #(
  parameter int DEPTH = 2,
  parameter int OP_W  = 4
);
  logic                     in_valid;
  logic [OP_W-1:0]          in_op;
  logic [31:0]              in_d1;
  logic [31:0]              in_d2;
  logic                     flush;
  logic                     md_busy;
  logic [OP_W-1:0]          out_op;
  logic [31:0]              out_d1;
  logic [31:0]              out_d2;
  logic                     stall;
  logic [$clog2(DEPTH):0]   pending;

  modport master (
    output in_valid, in_op, in_d1, in_d2, flush, md_busy,
    input  out_op, out_d1, out_d2, stall, pending
  );

  modport slave (
    input  in_valid, in_op, in_d1, in_d2, flush, md_busy,
    output out_op, out_d1, out_d2, stall, pending
  );
endinterface
`default_nettype wire

// File: rtl/md_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_issue_queue                                                             |
// | In-order FIFO feeding the HI/LO MD unit; raises stall on full / mfhi-mflo. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module md_issue_queue #(
  parameter int DEPTH = 2,
  parameter int OP_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  md_issue_queue_if.slave bus
);
  localparam int                 C_PTR_W = $clog2(DEPTH);
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

  logic [OP_W-1:0]    r_op [DEPTH];
  logic [31:0]        r_d1 [DEPTH];
  logic [31:0]        r_d2 [DEPTH];
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_CNT_W-1:0] r_count;

  logic w_is_enq;
  logic w_is_read;
  logic w_issue;
  logic w_accept;

  always_comb begin
    w_is_enq  = 1'b0;
    w_is_read = 1'b0;
    case (int'(bus.in_op))
      1, 2, 3, 4, 9, 10, 11, 12: w_is_enq  = 1'b1;
      7, 8:                      w_is_enq  = 1'b1;
      5, 6:                      w_is_read = 1'b1;
      default: ;
    endcase
  end

  assign w_issue  = (r_count != '0) && !bus.md_busy;
  assign w_accept = bus.in_valid && w_is_enq && !bus.flush &&
                    ((r_count < C_DEPTH) || w_issue);

  // mfhi/mflo must wait for every older MD op to finish writing HI/LO
  assign bus.stall = bus.in_valid && !bus.flush &&
                     ((w_is_enq && (r_count == C_DEPTH) && !w_issue) ||
                      (w_is_read && ((r_count != '0) || bus.md_busy)));

  assign bus.out_op  = w_issue ? r_op[r_rd_ptr] : '0;
  assign bus.out_d1  = w_issue ? r_d1[r_rd_ptr] : '0;
  assign bus.out_d2  = w_issue ? r_d2[r_rd_ptr] : '0;
  assign bus.pending = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i] <= '0;
        r_d1[i] <= '0;
        r_d2[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_op[r_wr_ptr] <= bus.in_op;
        r_d1[r_wr_ptr] <= bus.in_d1;
        r_d2[r_wr_ptr] <= bus.in_d2;
        r_wr_ptr       <= r_wr_ptr + C_PTR_ONE;
      end
      // An issue in the flush cycle still reaches the MD unit; its entry is just dropped.
      if (bus.flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
        r_count <= r_count + {{C_PTR_W{1'b0}}, w_accept} - {{C_PTR_W{1'b0}}, w_issue};
      end
    end
  end
endmodule
`default_nettype wire
